// File: rtl/jump_ctrl_sequencer.sv
// Hardwired T-state control sequencer: fetch, decode, jal/jr/branch,
// external execute handoff, halt/stop parking and memory-read timeout.
module jump_ctrl_sequencer #(
  parameter int          INST_W   = 32,
  parameter int          OPC_W    = 5,
  parameter logic [4:0]  OPC_JAL  = 5'b10011,
  parameter logic [4:0]  OPC_JR   = 5'b10100,
  parameter logic [4:0]  OPC_BR   = 5'b10010,
  parameter logic [4:0]  OPC_HALT = 5'b11011,
  parameter logic [4:0]  OPC_NOP  = 5'b11010,
  parameter int          WAIT_MAX = 15
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [INST_W-1:0] Ir,
  input  logic              MemReady,
  input  logic              CON,
  input  logic              Start,
  input  logic              Stop,
  input  logic              ExtDone,
  output logic              ExtReq,
  output logic              PCout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              MARin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              IncPC,
  output logic              Read,
  output logic              Gra,
  output logic              Rout,
  output logic              Rin,
  output logic              Cout,
  output logic              CONIn,
  output logic              LinkSel,
  output logic              AluAdd,
  output logic              Run,
  output logic              MemErr
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_STOP, S_HALT, S_ERR,
    S_T0, S_T1, S_T2, S_T3,
    S_J4, S_J5, S_R4,
    S_B4, S_B5, S_B6, S_B7,
    S_EXT
  } state_e;

  typedef struct packed {
    logic mem_err;
    logic run;
    logic ext_req;
    logic alu_add;
    logic link_sel;
    logic con_in;
    logic c_out;
    logic r_in;
    logic r_out;
    logic gra;
    logic read;
    logic inc_pc;
    logic y_in;
    logic ir_in;
    logic mdr_in;
    logic pc_in;
    logic z_in;
    logic mar_in;
    logic mdr_out;
    logic zlow_out;
    logic pc_out;
  } strobe_t;

  state_e     st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  strobe_t    s_q, s_d;
  logic [OPC_W-1:0] opc;
  state_e     eoi;

  logic unused_ir;
  assign unused_ir = ^Ir[INST_W-OPC_W-1:0];

  assign opc = Ir[INST_W-1 -: OPC_W];
  assign eoi = Stop ? S_STOP : S_T0;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      S_STOP, S_HALT: if (Start && !Stop) st_d = S_T0;
      S_ERR:          st_d = S_ERR;
      S_T0: begin
        st_d  = S_T1;
        cnt_d = '0;
      end
      S_T1: begin
        if (MemReady) st_d = S_T2;
        else if (cnt_q == CNT_W'(WAIT_MAX - 1)) st_d = S_ERR;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_T2: st_d = S_T3;
      S_T3: begin
        unique case (1'b1)
          opc == OPC_JAL:  st_d = S_J4;
          opc == OPC_JR:   st_d = S_R4;
          opc == OPC_BR:   st_d = S_B4;
          opc == OPC_HALT: st_d = S_HALT;
          opc == OPC_NOP:  st_d = eoi;
          default:         st_d = S_EXT;
        endcase
      end
      S_J4: st_d = S_J5;
      S_B4: st_d = S_B5;
      S_B5: st_d = S_B6;
      S_B6: st_d = S_B7;
      S_J5, S_R4, S_B7: st_d = eoi;
      S_EXT: if (ExtDone) st_d = eoi;
      default: st_d = S_STOP;
    endcase
  end

  // Strobes are decoded from the next state so they appear with it.
  always_comb begin
    s_d = '0;
    unique case (st_d)
      S_T0: begin
        s_d.pc_out = 1'b1;
        s_d.mar_in = 1'b1;
        s_d.inc_pc = 1'b1;
        s_d.z_in   = 1'b1;
      end
      S_T1: begin
        s_d.zlow_out = 1'b1;
        s_d.read     = 1'b1;
        s_d.mdr_in   = 1'b1;
        s_d.pc_in    = (st_q != S_T1);
      end
      S_T2: begin
        s_d.mdr_out = 1'b1;
        s_d.ir_in   = 1'b1;
      end
      S_J4: begin
        s_d.pc_out   = 1'b1;
        s_d.r_in     = 1'b1;
        s_d.link_sel = 1'b1;
      end
      S_J5, S_R4: begin
        s_d.gra   = 1'b1;
        s_d.r_out = 1'b1;
        s_d.pc_in = 1'b1;
      end
      S_B4: begin
        s_d.gra    = 1'b1;
        s_d.r_out  = 1'b1;
        s_d.con_in = 1'b1;
      end
      S_B5: begin
        s_d.pc_out = 1'b1;
        s_d.y_in   = 1'b1;
      end
      S_B6: begin
        s_d.c_out   = 1'b1;
        s_d.alu_add = 1'b1;
        s_d.z_in    = 1'b1;
      end
      // CON FF is settled since B4; registering it here makes B7's PCin.
      S_B7: begin
        s_d.zlow_out = 1'b1;
        s_d.pc_in    = CON;
      end
      S_EXT:   s_d.ext_req = 1'b1;
      S_ERR:   s_d.mem_err = 1'b1;
      default: s_d = '0;
    endcase
    s_d.run = !(st_d inside {S_STOP, S_HALT, S_ERR});
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      st_q  <= S_STOP;
      cnt_q <= '0;
      s_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
    end
  end

  assign ExtReq  = s_q.ext_req;
  assign PCout   = s_q.pc_out;
  assign Zlowout = s_q.zlow_out;
  assign MDRout  = s_q.mdr_out;
  assign MARin   = s_q.mar_in;
  assign Zin     = s_q.z_in;
  assign PCin    = s_q.pc_in;
  assign MDRin   = s_q.mdr_in;
  assign IRin    = s_q.ir_in;
  assign Yin     = s_q.y_in;
  assign IncPC   = s_q.inc_pc;
  assign Read    = s_q.read;
  assign Gra     = s_q.gra;
  assign Rout    = s_q.r_out;
  assign Rin     = s_q.r_in;
  assign Cout    = s_q.c_out;
  assign CONIn   = s_q.con_in;
  assign LinkSel = s_q.link_sel;
  assign AluAdd  = s_q.alu_add;
  assign Run     = s_q.run;
  assign MemErr  = s_q.mem_err;

endmodule

// File: tb/tb_jump_ctrl_sequencer.sv
// Scoreboard bench for jump_ctrl_sequencer: per-cycle expected strobe
// words are queued by the stimulus and checked by a negedge monitor.
module tb_jump_ctrl_sequencer;

  localparam logic [4:0] JAL  = 5'b10011;
  localparam logic [4:0] JR   = 5'b10100;
  localparam logic [4:0] BR   = 5'b10010;
  localparam logic [4:0] HALT = 5'b11011;
  localparam logic [4:0] NOP  = 5'b11010;

  localparam logic [20:0] PCOUT   = 21'(1) << 0;
  localparam logic [20:0] ZLOW    = 21'(1) << 1;
  localparam logic [20:0] MDROUT  = 21'(1) << 2;
  localparam logic [20:0] MARIN   = 21'(1) << 3;
  localparam logic [20:0] ZIN     = 21'(1) << 4;
  localparam logic [20:0] PCIN    = 21'(1) << 5;
  localparam logic [20:0] MDRIN   = 21'(1) << 6;
  localparam logic [20:0] IRIN    = 21'(1) << 7;
  localparam logic [20:0] YIN     = 21'(1) << 8;
  localparam logic [20:0] INCPC   = 21'(1) << 9;
  localparam logic [20:0] READ    = 21'(1) << 10;
  localparam logic [20:0] GRA     = 21'(1) << 11;
  localparam logic [20:0] ROUT    = 21'(1) << 12;
  localparam logic [20:0] RIN     = 21'(1) << 13;
  localparam logic [20:0] COUT    = 21'(1) << 14;
  localparam logic [20:0] CONIN   = 21'(1) << 15;
  localparam logic [20:0] LINKSEL = 21'(1) << 16;
  localparam logic [20:0] ALUADD  = 21'(1) << 17;
  localparam logic [20:0] EXTREQ  = 21'(1) << 18;
  localparam logic [20:0] RUN     = 21'(1) << 19;
  localparam logic [20:0] MEMERR  = 21'(1) << 20;

  localparam logic [20:0] E_T0  = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [20:0] E_T1  = ZLOW | READ | MDRIN | RUN;
  localparam logic [20:0] E_T2  = MDROUT | IRIN | RUN;
  localparam logic [20:0] E_J4  = PCOUT | RIN | LINKSEL | RUN;
  localparam logic [20:0] E_J5  = GRA | ROUT | PCIN | RUN;
  localparam logic [20:0] E_B4  = GRA | ROUT | CONIN | RUN;
  localparam logic [20:0] E_B5  = PCOUT | YIN | RUN;
  localparam logic [20:0] E_B6  = COUT | ALUADD | ZIN | RUN;

  logic Clock = 1'b0;
  logic Clear, MemReady, CON, Start, Stop, ExtDone;
  logic [31:0] Ir;
  logic ExtReq, PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin;
  logic IRin, Yin, IncPC, Read, Gra, Rout, Rin, Cout, CONIn;
  logic LinkSel, AluAdd, Run, MemErr;
  logic [20:0] outv;

  int checks = 0;
  int failures = 0;
  logic [20:0] expq[$];
  string namq[$];
  bit running = 0;

  always #5 Clock = ~Clock;

  jump_ctrl_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Ir(Ir), .MemReady(MemReady),
    .CON(CON), .Start(Start), .Stop(Stop), .ExtDone(ExtDone),
    .ExtReq(ExtReq), .PCout(PCout), .Zlowout(Zlowout),
    .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .Gra(Gra), .Rout(Rout), .Rin(Rin), .Cout(Cout),
    .CONIn(CONIn), .LinkSel(LinkSel), .AluAdd(AluAdd), .Run(Run),
    .MemErr(MemErr)
  );

  assign outv = {MemErr, Run, ExtReq, AluAdd, LinkSel, CONIn, Cout,
                 Rin, Rout, Gra, Read, IncPC, Yin, IRin, MDRin, PCin,
                 Zin, MARin, MDRout, Zlowout, PCout};

  always @(negedge Clock) begin
    if (expq.size() > 0) begin
      logic [20:0] e;
      string nm;
      e = expq.pop_front();
      nm = namq.pop_front();
      checks++;
      if (outv !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h t=%0t", nm, outv, e, $time);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input logic [20:0] e, input string nm,
                     input logic mr, input logic cn, input logic ed);
    MemReady = mr;
    CON = cn;
    ExtDone = ed;
    expq.push_back(e);
    namq.push_back(nm);
    @(posedge Clock);
    #1;
  endtask

  task automatic park(input int n);
    for (int i = 0; i < n; i++) begin
      Stop = rb();
      Start = Stop ? rb() : 1'b0;
      cyc('0, "parked", rb(), rb(), rb());
    end
  endtask

  task automatic resume();
    Stop = 1'b0;
    Start = 1'b1;
    cyc('0, "park_exit", rb(), rb(), rb());
    Start = rb();
    running = 1;
  endtask

  task automatic fetch(input logic [31:0] ir, input int waits);
    Ir = ir;
    cyc(E_T0, "T0", rb(), rb(), rb());
    for (int w = 0; w <= waits; w++)
      cyc(E_T1 | ((w == 0) ? PCIN : 21'(0)), "T1",
          (w == waits), rb(), rb());
    cyc(E_T2, "T2", rb(), rb(), rb());
  endtask

  task automatic instr(input logic [31:0] ir, input int waits,
                       input logic con, input int extlat,
                       input logic stp);
    logic [4:0] opc;
    opc = ir[31:27];
    Stop = stp;
    fetch(ir, waits);
    cyc(RUN, "T3", rb(), rb(), rb());
    if (opc == JAL) begin
      cyc(E_J4, "J4", rb(), rb(), rb());
      cyc(E_J5, "J5", rb(), rb(), rb());
    end else if (opc == JR) begin
      cyc(E_J5, "R4", rb(), rb(), rb());
    end else if (opc == BR) begin
      cyc(E_B4, "B4", rb(), con, rb());
      cyc(E_B5, "B5", rb(), con, rb());
      cyc(E_B6, "B6", rb(), con, rb());
      cyc(ZLOW | RUN | (con ? PCIN : 21'(0)), "B7", rb(), con, rb());
    end else if (opc != HALT && opc != NOP) begin
      for (int e = 0; e < extlat; e++)
        cyc(EXTREQ | RUN, "EXT", rb(), rb(), (e == extlat - 1));
    end
    running = !(stp || opc == HALT);
  endtask

  initial begin
    logic [4:0] opc;
    int r;
    Clear = 1'b0;
    Start = 1'b0;
    Stop = 1'b0;
    MemReady = 1'b0;
    CON = 1'b0;
    ExtDone = 1'b0;
    Ir = '0;
    @(posedge Clock);
    #1;
    cyc('0, "reset", 1'b1, 1'b1, 1'b1);
    Start = 1'b1;
    cyc('0, "reset_start", 1'b1, 1'b1, 1'b1);
    Clear = 1'b1;
    Start = 1'b0;
    cyc('0, "stop_idle", 1'b0, 1'b0, 1'b0);
    resume();

    instr(32'h98800000, 0, 1'b0, 1, 1'b0);
    instr({JR, 27'h0}, 3, 1'b0, 1, 1'b0);
    instr({BR, 27'h1234}, 0, 1'b0, 1, 1'b0);
    instr({BR, 27'h1234}, 1, 1'b1, 1, 1'b0);
    instr({5'b00011, 27'h55}, 0, 1'b0, 5, 1'b0);
    instr({5'b00011, 27'h0}, 0, 1'b0, 1, 1'b0);
    instr({NOP, 27'h7ffffff}, 0, 1'b0, 1, 1'b0);
    instr({HALT, 27'h0}, 0, 1'b0, 1, 1'b0);
    Stop = 1'b0;
    Start = 1'b0;
    cyc('0, "halt_wait", 1'b1, 1'b1, 1'b1);
    cyc('0, "halt_wait", 1'b1, 1'b1, 1'b1);
    Stop = 1'b1;
    Start = 1'b1;
    cyc('0, "start_and_stop", 1'b1, 1'b1, 1'b1);
    resume();
    instr({NOP, 27'h0}, 0, 1'b0, 1, 1'b1);
    park(2);
    resume();

    for (int n = 0; n < 80; n++) begin
      if (!running) begin
        park($urandom_range(0, 2));
        resume();
      end
      r = $urandom_range(0, 9);
      case (r)
        0, 1: opc = JAL;
        2, 3: opc = JR;
        4, 5: opc = BR;
        6: opc = NOP;
        7: opc = HALT;
        default: begin
          opc = 5'($urandom);
          while (opc inside {JAL, JR, BR, NOP, HALT})
            opc = 5'($urandom);
        end
      endcase
      instr({opc, 27'($urandom)}, $urandom_range(0, 4), rb(),
            $urandom_range(1, 6), ($urandom_range(0, 5) == 0));
    end

    if (!running) resume();
    Stop = 1'b0;
    fetch(32'h98800000, 0);
    cyc(RUN, "T3", 1'b0, 1'b0, 1'b0);
    expq.push_back(E_J4);
    namq.push_back("J4_pre_clear");
    @(negedge Clock);
    #1 Clear = 1'b0;
    #1;
    checks++;
    if (outv !== 21'(0)) begin
      failures++;
      $display("FAIL async_clear got=%h exp=%h", outv, 21'(0));
    end
    @(posedge Clock);
    #1;
    Start = 1'b1;
    cyc('0, "clear_held", 1'b1, 1'b1, 1'b1);
    Clear = 1'b1;
    Start = 1'b0;
    cyc('0, "after_clear", 1'b1, 1'b1, 1'b1);
    resume();

    Ir = {NOP, 27'h0};
    cyc(E_T0, "T0", 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 15; w++)
      cyc(E_T1 | ((w == 0) ? PCIN : 21'(0)), "T1_timeout",
          1'b0, rb(), rb());
    Start = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(MEMERR, "ERR", rb(), rb(), rb());
    Clear = 1'b0;
    cyc('0, "err_clear", 1'b1, 1'b1, 1'b1);
    Clear = 1'b1;
    Start = 1'b0;
    cyc('0, "after_err_clear", 1'b1, 1'b1, 1'b1);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
